protocol_channel_bridge: RTL and testbench
==========================================

PROTOCOL_CHANNEL_BRIDGE -- requirements
Module: protocol_channel_bridge

Interface
REQ-001 Parameters SHALL be as follows:
- DATA_W, 32, word width.
- CHANNELS, 4, number of channel registers (1..8).
- DEPTH, 8, import FIFO depth (power of two, 2..64).
REQ-002 Ports SHALL be as follows:
- clock  in  1  sole clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  4  host register index.
- write  in  1  host write strobe.
- writedata  in  DATA_W  host write data.
- read  in  1  host read strobe.
- readdata  out  DATA_W  host read data, registered.
- readdatavalid  out  1  pulses when readdata holds a read result.
- writeEnable  in  1  import strobe.
- import_ch  in  3  import target channel.
- data_import  in  DATA_W  import data.
- data_export  out  CHANNELS*DATA_W  channel registers concatenated; channel k at bits [k*DATA_W +: DATA_W].
- irq  out  1  level: FIFO non-empty or any sticky flag set.

Function
REQ-003 Address map SHALL be:
- 0..CHANNELS-1: channel register k (R/W).
- CHANNELS: FIFO pop (R).
- CHANNELS+1: STATUS (R; W1C).
- Other addresses read 0; writes to them are ignored.
REQ-004 A host write to channel k SHALL load writedata into channel register k at the next clock edge.
REQ-005 An import (writeEnable=1, import_ch<CHANNELS) SHALL do both of the following in the same edge:
- load data_import into channel register import_ch;
- push {import_ch, data_import} into the FIFO.
REQ-006 An import with import_ch>=CHANNELS SHALL be dropped entirely and SHALL set the sticky BADCH flag.
REQ-007 Host write and import to the same channel in the same cycle:
- the import value SHALL win;
- the sticky COLL flag SHALL be set.
- Host write and import to different channels in the same cycle SHALL both take effect.
REQ-008 FIFO full and import arrives:
- the data SHALL be discarded and the FIFO left unchanged;
- the sticky OVF flag SHALL be set;
- the channel register SHALL still be updated.
REQ-009 Read latency SHALL be exactly 1 cycle: readdata and readdatavalid are valid in the cycle after read=1. readdatavalid SHALL be 1 for that cycle only.
REQ-010 A read of the FIFO-pop address with the FIFO non-empty SHALL return the oldest entry data and remove it.
REQ-011 A read of the FIFO-pop address with the FIFO empty SHALL return 0, SHALL leave the FIFO unchanged, and SHALL set the sticky UNF flag.
REQ-012 Push and pop in the same cycle SHALL both occur and leave the count unchanged, including when the FIFO is full: the pop frees the slot, so no OVF. A simultaneous push and pop with the FIFO empty SHALL be treated as an empty read (UNF set, push accepted).
REQ-013 STATUS read SHALL return these fields, other bits 0:
- [6:0] count
- [7] empty
- [8] full
- [9] OVF
- [10] UNF
- [11] COLL
- [12] BADCH
- [15:13] channel of FIFO head (0 when empty)
REQ-014 A STATUS write SHALL clear each sticky flag whose writedata bit is 1. A flag set in the same cycle SHALL remain set.
REQ-015 FIFO pointers SHALL wrap modulo DEPTH. count SHALL range 0..DEPTH with no aliasing at full.
REQ-016 Simultaneous read and write SHALL both be serviced. A read of a channel being written SHALL return the pre-write value.
REQ-017 data_export SHALL reflect the channel registers directly from the flops, with no combinational path from inputs.

Reset
REQ-018 While reset=1, the following SHALL be held at 0 and all strobes ignored:
- channel registers;
- readdata and readdatavalid;
- FIFO pointers and count;
- all sticky flags;
- irq.
REQ-019 Reset asserted mid-operation SHALL discard FIFO contents and any pending read response; readdatavalid SHALL be 0 in the cycle after reset.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Host write 0xA5A5_0001 to address 2, then read address 2 -> readdatavalid one cycle after read, readdata=0xA5A5_0001, data_export[95:64]=0xA5A5_0001.
- Host write 0x1111 and import 0x2222 both to channel 1 in the same cycle -> channel 1=0x2222, STATUS.COLL=1, irq=1; write 0x800 to STATUS -> COLL=0.
- 9 imports with DEPTH=8 and no pops -> count=8, full=1, OVF=1, channel register holds the 9th value; 8 pops return entries 1..8 in order, then a 9th pop returns 0 with UNF=1.
- FIFO full, import and pop in the same cycle -> count stays 8, OVF not set, popped value is the oldest entry.
- Import with import_ch=7 at CHANNELS=4 -> BADCH=1, count and all channel registers unchanged.
- 3 imports queued, then reset pulsed for 1 cycle -> all outputs 0, STATUS reads 0x80 (empty only).

Source files
------------

// File: rtl/protocol_channel_bridge.sv
// Host-visible channel register bank with an import port that also logs
// {channel, data} into a FIFO the host drains through a pop register.
module protocol_channel_bridge #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DEPTH    = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [3:0]                 address,
    input  logic                       write,
    input  logic [DATA_W-1:0]          writedata,
    input  logic                       read,
    output logic [DATA_W-1:0]          readdata,
    output logic                       readdatavalid,
    input  logic                       writeEnable,
    input  logic [2:0]                 import_ch,
    input  logic [DATA_W-1:0]          data_import,
    output logic [CHANNELS*DATA_W-1:0] data_export,
    output logic                       irq
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = DATA_W + 3;
    localparam logic [3:0] ADDR_POP    = 4'(CHANNELS);
    localparam logic [3:0] ADDR_STATUS = 4'(CHANNELS + 1);

    typedef enum logic [1:0] {
        FLAG_OVF   = 2'd0,
        FLAG_UNF   = 2'd1,
        FLAG_COLL  = 2'd2,
        FLAG_BADCH = 2'd3
    } flag_e;

    logic [DATA_W-1:0] chan_q [CHANNELS];
    logic [DATA_W-1:0] chan_d [CHANNELS];
    logic [ENT_W-1:0]  mem_q  [DEPTH];
    logic [ENT_W-1:0]  mem_d  [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [3:0]        flags_q, flags_d;
    logic [DATA_W-1:0] readdata_q, readdata_d;
    logic              readdatavalid_q, readdatavalid_d;

    logic              empty, full;
    logic              imp_ok, imp_bad, rd_pop, pop, push;
    logic [ENT_W-1:0]  head;
    logic [DATA_W-1:0] status, rd_val;
    logic [3:0]        flag_set, flag_clr;

    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == CNT_W'(DEPTH));
        imp_ok  = writeEnable && ({1'b0, import_ch} < 4'(CHANNELS));
        imp_bad = writeEnable && !imp_ok;
        rd_pop  = read && (address == ADDR_POP);
        pop     = rd_pop && !empty;
        // a pop in the same cycle frees the slot, so a full FIFO still accepts
        push    = imp_ok && (!full || pop);
        head    = mem_q[rd_ptr_q];

        status        = '0;
        status[6:0]   = 7'(count_q);
        status[7]     = empty;
        status[8]     = full;
        status[12:9]  = flags_q;
        status[15:13] = empty ? 3'd0 : head[ENT_W-1 -: 3];

        rd_val = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (address == 4'(k)) rd_val = chan_q[k];
        end
        if (address == ADDR_POP)    rd_val = pop ? head[DATA_W-1:0] : '0;
        if (address == ADDR_STATUS) rd_val = status;

        chan_d = chan_q;
        flag_set = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            if (write && address == 4'(k)) chan_d[k] = writedata;
            if (imp_ok && import_ch == 3'(k)) begin
                chan_d[k] = data_import;
                if (write && address == 4'(k)) flag_set[FLAG_COLL] = 1'b1;
            end
        end

        flag_set[FLAG_OVF]   = imp_ok && full && !pop;
        flag_set[FLAG_UNF]   = rd_pop && empty;
        flag_set[FLAG_BADCH] = imp_bad;
        flag_clr = (write && address == ADDR_STATUS) ? writedata[12:9] : '0;
        flags_d  = (flags_q & ~flag_clr) | flag_set;

        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = {import_ch, data_import};
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);

        readdata_d      = read ? rd_val : readdata_q;
        readdatavalid_d = read;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            chan_q          <= '{default: '0};
            rd_ptr_q        <= '0;
            wr_ptr_q        <= '0;
            count_q         <= '0;
            flags_q         <= '0;
            readdata_q      <= '0;
            readdatavalid_q <= 1'b0;
        end else begin
            chan_q          <= chan_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            count_q         <= count_d;
            flags_q         <= flags_d;
            readdata_q      <= readdata_d;
            readdatavalid_q <= readdatavalid_d;
        end
    end

    // storage needs no reset: occupancy is governed by pointers and count
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_export
        assign data_export[k*DATA_W +: DATA_W] = chan_q[k];
    end

    assign readdata      = readdata_q;
    assign readdatavalid = readdatavalid_q;
    assign irq           = (count_q != '0) || (|flags_q);

endmodule

// File: tb/tb_protocol_channel_bridge.sv
// Bench for protocol_channel_bridge: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based model.
module tb_protocol_channel_bridge;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [3:0]   address = '0;
    logic         write = 1'b0;
    logic [31:0]  writedata = '0;
    logic         read = 1'b0;
    logic [31:0]  readdata;
    logic         readdatavalid;
    logic         writeEnable = 1'b0;
    logic [2:0]   import_ch = '0;
    logic [31:0]  data_import = '0;
    logic [127:0] data_export;
    logic         irq;

    int n_checks = 0;
    int n_errors = 0;

    protocol_channel_bridge #(.DATA_W(32), .CHANNELS(4), .DEPTH(8)) dut (
        .clock(clock), .reset(reset), .address(address), .write(write),
        .writedata(writedata), .read(read), .readdata(readdata),
        .readdatavalid(readdatavalid), .writeEnable(writeEnable),
        .import_ch(import_ch), .data_import(data_import),
        .data_export(data_export), .irq(irq)
    );

    always #5 clock = ~clock;

    // reference model: channel array, FIFO queue of {ch, data}, sticky flags
    logic [31:0] m_chan [4];
    logic [34:0] m_q [$];
    bit m_ovf, m_unf, m_coll, m_bad;

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = '0;
        s[6:0] = 7'(m_q.size());
        s[7] = (m_q.size() == 0);
        s[8] = (m_q.size() == 8);
        s[9] = m_ovf;
        s[10] = m_unf;
        s[11] = m_coll;
        s[12] = m_bad;
        s[15:13] = (m_q.size() != 0) ? m_q[0][34:32] : 3'd0;
        return s;
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] ad);
        if (ad < 4) return m_chan[ad[1:0]];
        if (ad == 4) return (m_q.size() != 0) ? m_q[0][31:0] : 32'd0;
        if (ad == 5) return m_status();
        return 32'd0;
    endfunction

    function automatic logic [127:0] m_export();
        logic [127:0] e;
        for (int k = 0; k < 4; k++) e[k*32 +: 32] = m_chan[k];
        return e;
    endfunction

    function automatic bit m_irq();
        return (m_q.size() != 0) || m_ovf || m_unf || m_coll || m_bad;
    endfunction

    task automatic m_clear();
        for (int k = 0; k < 4; k++) m_chan[k] = '0;
        m_q.delete();
        m_ovf = 0; m_unf = 0; m_coll = 0; m_bad = 0;
    endtask

    task automatic m_apply(input bit wr, input logic [3:0] ad, input logic [31:0] wd,
                           input bit rd, input bit we, input logic [2:0] ch,
                           input logic [31:0] di);
        bit popping, was_full;
        popping  = rd && ad == 4 && m_q.size() != 0;
        was_full = (m_q.size() == 8);
        if (wr && ad == 5) begin
            if (wd[9])  m_ovf  = 0;
            if (wd[10]) m_unf  = 0;
            if (wd[11]) m_coll = 0;
            if (wd[12]) m_bad  = 0;
        end
        if (rd && ad == 4 && m_q.size() == 0) m_unf = 1;
        if (popping) void'(m_q.pop_front());
        if (wr && ad < 4) begin
            if (we && ch == ad[2:0]) m_coll = 1;
            else m_chan[ad[1:0]] = wd;
        end
        if (we) begin
            if (ch < 4) begin
                m_chan[ch[1:0]] = di;
                if (was_full && !popping) m_ovf = 1;
                else m_q.push_back({ch, di});
            end else begin
                m_bad = 1;
            end
        end
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input bit wr, input logic [3:0] ad, input logic [31:0] wd,
                        input bit rd, input bit we, input logic [2:0] ch,
                        input logic [31:0] di, input bit chk, input logic [31:0] exp,
                        input string name);
        logic [31:0] mexp;
        mexp = m_read(ad);
        write = wr; address = ad; writedata = wd; read = rd;
        writeEnable = we; import_ch = ch; data_import = di;
        m_apply(wr, ad, wd, rd, we, ch, di);
        @(posedge clock);
        #1;
        check({name, "_rdv"}, 128'(readdatavalid), 128'(rd));
        if (rd) check({name, "_rdata_model"}, 128'(readdata), 128'(mexp));
        if (chk) check({name, "_rdata"}, 128'(readdata), 128'(exp));
        check({name, "_export"}, data_export, m_export());
        check({name, "_irq"}, 128'(irq), 128'(m_irq()));
        write = 0; read = 0; writeEnable = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        read = 1; address = 4'd4; write = $urandom_range(0, 1);
        writedata = $urandom; writeEnable = 1; import_ch = 3'($urandom_range(0, 3));
        data_import = $urandom;
        @(posedge clock);
        #1;
        check("rst_rdv", 128'(readdatavalid), 128'd0);
        check("rst_rdata", 128'(readdata), 128'd0);
        check("rst_export", data_export, 128'd0);
        check("rst_irq", 128'(irq), 128'd0);
        m_clear();
        reset = 0; read = 0; write = 0; writeEnable = 0;
    endtask

    typedef struct {
        bit          wr;
        logic [3:0]  ad;
        logic [31:0] wd;
        bit          rd;
        bit          we;
        logic [2:0]  ch;
        logic [31:0] di;
        bit          chk;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [9];

    initial begin
        tbl[0] = '{1, 4'd2, 32'hA5A5_0001, 0, 0, 3'd0, 32'h0,    0, 32'h0};
        tbl[1] = '{0, 4'd2, 32'h0,         1, 0, 3'd0, 32'h0,    1, 32'hA5A5_0001};
        tbl[2] = '{1, 4'd1, 32'h1111,      0, 1, 3'd1, 32'h2222, 0, 32'h0};
        tbl[3] = '{0, 4'd1, 32'h0,         1, 0, 3'd0, 32'h0,    1, 32'h2222};
        tbl[4] = '{0, 4'd5, 32'h0,         1, 0, 3'd0, 32'h0,    1, 32'h2801};
        tbl[5] = '{1, 4'd5, 32'h800,       0, 0, 3'd0, 32'h0,    0, 32'h0};
        tbl[6] = '{0, 4'd5, 32'h0,         1, 0, 3'd0, 32'h0,    1, 32'h2001};
        tbl[7] = '{0, 4'd4, 32'h0,         1, 0, 3'd0, 32'h0,    1, 32'h2222};
        tbl[8] = '{0, 4'd5, 32'h0,         1, 0, 3'd0, 32'h0,    1, 32'h80};

        m_clear();
        do_reset();

        for (int i = 0; i < 9; i++) begin
            step(tbl[i].wr, tbl[i].ad, tbl[i].wd, tbl[i].rd, tbl[i].we,
                 tbl[i].ch, tbl[i].di, tbl[i].chk, tbl[i].exp, $sformatf("tbl%0d", i));
            if (i == 1) check("tbl_export_ch2", 128'(data_export[95:64]), 128'hA5A5_0001);
            if (i == 4) check("tbl_coll_irq", 128'(irq), 128'd1);
        end

        // overflow then drain to underflow
        do_reset();
        for (int i = 1; i <= 9; i++) step(0, 4'd0, 0, 0, 1, 3'd0, 32'(i), 0, 0, "ovf_imp");
        step(0, 4'd5, 0, 1, 0, 3'd0, 0, 1, 32'h308, "ovf_status");
        check("ovf_chan0", 128'(data_export[31:0]), 128'd9);
        for (int i = 1; i <= 8; i++) step(0, 4'd4, 0, 1, 0, 3'd0, 0, 1, 32'(i), "drain_pop");
        step(0, 4'd4, 0, 1, 0, 3'd0, 0, 1, 32'h0, "unf_pop");
        step(0, 4'd5, 0, 1, 0, 3'd0, 0, 1, 32'h680, "unf_status");
        step(1, 4'd5, 32'h1E00, 0, 0, 3'd0, 0, 0, 0, "clr_all");

        // full FIFO with simultaneous push and pop
        for (int i = 0; i < 8; i++) step(0, 4'd0, 0, 0, 1, 3'd2, 32'h100 + 32'(i), 0, 0, "fill");
        step(0, 4'd4, 0, 1, 1, 3'd3, 32'h999, 1, 32'h100, "full_pushpop");
        check("full_pushpop_ch3", 128'(data_export[127:96]), 128'h999);
        step(0, 4'd5, 0, 1, 0, 3'd0, 0, 1, 32'h4108, "full_pushpop_status");

        // bad channel import, then W1C racing a fresh set of the same flag
        step(0, 4'd0, 0, 0, 1, 3'd7, 32'hDEAD_BEEF, 0, 0, "badch_imp");
        step(0, 4'd5, 0, 1, 0, 3'd0, 0, 1, 32'h5108, "badch_status");
        step(1, 4'd5, 32'h1000, 0, 1, 3'd7, 32'h1, 0, 0, "w1c_race");
        step(0, 4'd5, 0, 1, 0, 3'd0, 0, 1, 32'h5108, "w1c_race_status");

        // reset while entries are queued
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 4'd0, 0, 0, 1, 3'(i), 32'hC0 + 32'(i), 0, 0, "q3");
        do_reset();
        step(0, 4'd0, 0, 0, 0, 3'd0, 0, 0, 0, "post_rst_idle");
        step(0, 4'd5, 0, 1, 0, 3'd0, 0, 1, 32'h80, "post_rst_status");

        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                logic [2:0] ch;
                ch = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
                step($urandom_range(0, 3) == 0, 4'($urandom_range(0, 7)), $urandom,
                     $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, ch, $urandom,
                     0, 0, "rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
